// File: rtl/ghash_seq.sv
// ghash_seq: message sequencer in front of the GHASH core.
// Takes AD and payload blocks over one valid/ready stream. Each block is
// masked to its valid bytes and added to the bit-length counters, then the
// matching one-cycle GHASH command is issued. At the end of the message the
// length block is finalized and tag = gh_X ^ tag_mask is registered.
// Optional build macro GHASH_SEQ_TAG_CMP_EN adds the exp_tag input and the
// tag_ok/tag_fail outputs.
module ghash_seq #(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             msg_empty,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             blk_is_data,
  input  logic             blk_last,
  input  logic [4:0]       blk_bytes,
  input  logic [127:0]     blk_data,
  input  logic [127:0]     tag_mask,
  output logic             gh_first_init,
  output logic             gh_init,
  output logic             gh_next_no_ad,
  output logic             gh_next,
  output logic             gh_finalize_no_in,
  output logic             gh_finalize,
  output logic [127:0]     gh_ad,
  output logic [127:0]     gh_block,
  output logic [LEN_W-1:0] gh_len_ad,
  output logic [LEN_W-1:0] gh_len_i,
  input  logic             gh_ready,
  input  logic [127:0]     gh_X,
  output logic [127:0]     tag,
  output logic             tag_valid,
  output logic             order_err
`ifdef GHASH_SEQ_TAG_CMP_EN
  ,
  input  logic [127:0]     exp_tag,
  output logic             tag_ok,
  output logic             tag_fail
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_ISSUE, S_BUSY, S_FIN_ISSUE, S_FIN_BUSY, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_ad_q, len_ad_d, len_i_q, len_i_d;
  logic [127:0]       ad_q, ad_d, blk_q, blk_d, tag_q, tag_d;
  logic               seen_ad_q, seen_ad_d, seen_data_q, seen_data_d;
  logic               err_q, err_d, tv_q, tv_d;
  logic               last_q, last_d, isd_q, isd_d;
  logic [4:0]         nb;
  logic [127:0]       masked;
  logic [127:0]       tag_new;
`ifdef GHASH_SEQ_TAG_CMP_EN
  logic               ok_q, ok_d, fail_q, fail_d;
  logic               tag_eq;
`endif

  // Effective byte count (0 and >16 mean a full block) and zeroing of
  // the unused upper bytes.
  always_comb begin
    nb = (blk_bytes == 5'd0 || blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
    masked = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < nb) masked[8*i +: 8] = blk_data[8*i +: 8];
  end

  assign tag_new = gh_X ^ tag_mask;
`ifdef GHASH_SEQ_TAG_CMP_EN
  // Full-width XOR + reduction: same structure whatever the data, no early out.
  assign tag_eq = ~|(tag_new ^ exp_tag);
`endif

  // Next-state, datapath updates and the one-cycle command pulses.
  always_comb begin
    state_d     = state_q;
    len_ad_d    = len_ad_q;
    len_i_d     = len_i_q;
    ad_d        = ad_q;
    blk_d       = blk_q;
    tag_d       = tag_q;
    seen_ad_d   = seen_ad_q;
    seen_data_d = seen_data_q;
    err_d       = err_q;
    tv_d        = tv_q;
    last_d      = last_q;
    isd_d       = isd_q;
`ifdef GHASH_SEQ_TAG_CMP_EN
    ok_d        = ok_q;
    fail_d      = fail_q;
`endif
    blk_ready         = 1'b0;
    gh_first_init     = 1'b0;
    gh_init           = 1'b0;
    gh_next_no_ad     = 1'b0;
    gh_next           = 1'b0;
    gh_finalize_no_in = 1'b0;
    gh_finalize       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_ad_d    = '0;
          len_i_d     = '0;
          seen_ad_d   = 1'b0;
          seen_data_d = 1'b0;
          err_d       = 1'b0;
          tv_d        = 1'b0;
`ifdef GHASH_SEQ_TAG_CMP_EN
          ok_d        = 1'b0;
          fail_d      = 1'b0;
`endif
          state_d     = msg_empty ? S_FIN_ISSUE : S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          if (!blk_is_data && seen_data_q) begin
            // Out-of-order AD is swallowed; only the error flag records it.
            err_d = 1'b1;
            if (blk_last) state_d = S_FIN_ISSUE;
          end else begin
            if (blk_is_data) begin
              blk_d   = masked;
              len_i_d = len_i_q + LEN_W'({nb, 3'b000});
            end else begin
              ad_d     = masked;
              len_ad_d = len_ad_q + LEN_W'({nb, 3'b000});
            end
            isd_d   = blk_is_data;
            last_d  = blk_last;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // seen_* still reflect the blocks before this one here.
        if (!isd_q) begin
          gh_first_init = !seen_ad_q;
          gh_init       = seen_ad_q;
          seen_ad_d     = 1'b1;
        end else begin
          gh_next_no_ad = !seen_ad_q && !seen_data_q;
          gh_next       = seen_ad_q || seen_data_q;
          seen_data_d   = 1'b1;
        end
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (gh_ready) state_d = last_q ? S_FIN_ISSUE : S_WAIT_BLK;
      end
      S_FIN_ISSUE: begin
        gh_finalize_no_in = !seen_ad_q && !seen_data_q;
        gh_finalize       = seen_ad_q || seen_data_q;
        state_d           = S_FIN_BUSY;
      end
      S_FIN_BUSY: begin
        if (gh_ready) begin
          tag_d   = tag_new;
          tv_d    = 1'b1;
`ifdef GHASH_SEQ_TAG_CMP_EN
          ok_d    = tag_eq;
          fail_d  = !tag_eq;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_ad_q    <= '0;
      len_i_q     <= '0;
      ad_q        <= '0;
      blk_q       <= '0;
      tag_q       <= '0;
      seen_ad_q   <= 1'b0;
      seen_data_q <= 1'b0;
      err_q       <= 1'b0;
      tv_q        <= 1'b0;
      last_q      <= 1'b0;
      isd_q       <= 1'b0;
`ifdef GHASH_SEQ_TAG_CMP_EN
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_ad_q    <= len_ad_d;
      len_i_q     <= len_i_d;
      ad_q        <= ad_d;
      blk_q       <= blk_d;
      tag_q       <= tag_d;
      seen_ad_q   <= seen_ad_d;
      seen_data_q <= seen_data_d;
      err_q       <= err_d;
      tv_q        <= tv_d;
      last_q      <= last_d;
      isd_q       <= isd_d;
`ifdef GHASH_SEQ_TAG_CMP_EN
      ok_q        <= ok_d;
      fail_q      <= fail_d;
`endif
    end
  end

  assign gh_ad     = ad_q;
  assign gh_block  = blk_q;
  assign gh_len_ad = len_ad_q;
  assign gh_len_i  = len_i_q;
  assign tag       = tag_q;
  assign tag_valid = tv_q;
  assign order_err = err_q;
`ifdef GHASH_SEQ_TAG_CMP_EN
  assign tag_ok    = ok_q;
  assign tag_fail  = fail_q;
`endif

endmodule

// File: doc/ghash_seq.md
Name: ghash_seq

Overview:
Message sequencer directly upstream of the GHASH core (ghash_alt) in the SNOW-V AEAD datapath.
- Accepts AD and payload blocks over one valid/ready stream.
- Masks partial blocks, accumulates bit lengths and issues the matching one-cycle GHASH command per block.
- Drives the final length block and outputs tag = GHASH X xor tag_mask.

Parameters:
- LEN_W, 64, width of each bit-length counter; must stay 64 to match GHASH len_ad/len_i.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  begin new message; sampled in IDLE/DONE only
- msg_empty  in  1  qualifies start: message has no AD and no payload
- blk_valid  in  1  block offered
- blk_ready  out  1  block accepted when blk_valid & blk_ready
- blk_is_data  in  1  0 = AD block, 1 = payload (ciphertext) block
- blk_last  in  1  final block of the message
- blk_bytes  in  5  valid bytes in block, 1..16; 0 or >16 treated as 16
- blk_data  in  128  block; byte i at bits [8i+7:8i]
- tag_mask  in  128  keystream mask XORed into the tag; sampled when tag is formed
- gh_first_init, gh_init, gh_next_no_ad, gh_next, gh_finalize_no_in, gh_finalize  out  1 each  GHASH command pulses
- gh_ad, gh_block  out  128  masked block to GHASH; held stable from command until gh_ready
- gh_len_ad, gh_len_i  out  64  AD / payload bit counts
- gh_ready  in  1  GHASH completion pulse
- gh_X  in  128  GHASH accumulator
- tag  out  128  gh_X ^ tag_mask
- tag_valid  out  1  high from tag formation until next accepted start
- order_err  out  1  sticky: AD block offered after payload; cleared by start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; applies immediately, including mid-operation. GHASH is assumed reset by the same reset_n.
- States: IDLE, WAIT_BLK, ISSUE, BUSY, FIN_ISSUE, FIN_BUSY, DONE.
- IDLE/DONE + start:
  - Clear len counters, seen_ad, seen_data, order_err, tag_valid.
  - msg_empty=1: go to FIN_ISSUE. Otherwise go to WAIT_BLK.
- start in any other state is ignored.
- WAIT_BLK: blk_ready=1. On handshake:
  - Zero bytes i >= blk_bytes.
  - Latch the result into gh_ad (AD) or gh_block (data).
  - Add 8*blk_bytes to gh_len_ad or gh_len_i, modulo 2^64.
  - Latch blk_last, then go to ISSUE.
- AD block with seen_data=1: accepted, dropped, order_err set; no command, no length update, stays in WAIT_BLK. If blk_last is also set, go to FIN_ISSUE.
- ISSUE: assert exactly one command for one cycle, then go to BUSY.
  - AD, first in message: gh_first_init. AD, later: gh_init.
  - Data with no prior AD or data: gh_next_no_ad. Otherwise: gh_next.
- BUSY: wait for gh_ready. Then go to FIN_ISSUE if last, else WAIT_BLK. blk_ready=0 throughout.
- FIN_ISSUE: one-cycle pulse, then FIN_BUSY.
  - gh_finalize_no_in if neither seen_ad nor seen_data; else gh_finalize.
  - gh_len_* stay stable until gh_ready.
- FIN_BUSY + gh_ready: in the same cycle, register tag = gh_X ^ tag_mask and set tag_valid; next state DONE.
- Latency: handshake at cycle T gives command at T+1. blk_ready returns the cycle after gh_ready.
- Only the last AD block and the last data block may be partial; this is not checked.

Optional Feature:
- Macro: GHASH_SEQ_TAG_CMP_EN.
- Defined: adds input exp_tag[127:0] and outputs tag_ok and tag_fail.
  - On the cycle tag_valid rises, exactly one of tag_ok/tag_fail is set, from a constant-structure 128-bit compare.
  - Both hold until the next start and are 0 on reset.
- Undefined: ports absent, no compare logic.

Test Plan:
- start, msg_empty=1 -> single gh_finalize_no_in pulse, len_ad=len_i=0. With stub X=0 and tag_mask=0xA5..A5, tag=0xA5..A5 and tag_valid=1.
- Two AD blocks (16 B, then 5 B) + one data block (16 B, last) -> commands first_init, init, next, finalize; final len_ad=168, len_i=128. Second gh_ad carries only bytes 0..4, upper 11 bytes zero.
- No AD, data blocks 16 B + 1 B last -> next_no_ad, next, finalize; len_i=136, len_ad=0. gh_block for the 1-byte block has only bits [7:0] nonzero.
- AD after data -> order_err=1, no command and no length change; a following last data block completes normally.
- Reset asserted while in BUSY -> all outputs 0 immediately. Next start behaves as a fresh message with first_init.
- Against the real ghash_alt with a GCM test vector (AD 20 B, payload 60 B, tag_mask=0) -> tag matches the reference GHASH value. With GHASH_SEQ_TAG_CMP_EN, exp_tag equal gives tag_ok=1; exp_tag with 1 bit flipped gives tag_fail=1.
